// File: rtl/detection_bram_reader_if.sv
// rtl/detection_bram_reader_if.sv - BRAM read port and decoded bbox output of the detection reader
interface detection_bram_reader_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int COORD_WIDTH   = 16,
  parameter int MEMORY_WIDTH  = 32
);
  logic                     read_en_out_axi;
  logic [ADDRESS_WIDTH-1:0] read_address_out_axi;
  logic [MEMORY_WIDTH-1:0]  read_data_axi;
  logic [COORD_WIDTH-1:0]   bbox_x_start_out_axi;
  logic [COORD_WIDTH-1:0]   bbox_y_start_out_axi;
  logic [COORD_WIDTH-1:0]   bbox_x_end_out_axi;
  logic [COORD_WIDTH-1:0]   bbox_y_end_out_axi;
  logic                     bbox_valid_out_axi;
  logic                     bbox_ready_axi;

  modport master (
    output read_en_out_axi, read_address_out_axi,
    input  read_data_axi,
    output bbox_x_start_out_axi, bbox_y_start_out_axi, bbox_x_end_out_axi, bbox_y_end_out_axi,
    output bbox_valid_out_axi,
    input  bbox_ready_axi
  );

  modport slave (
    input  read_en_out_axi, read_address_out_axi,
    output read_data_axi,
    input  bbox_x_start_out_axi, bbox_y_start_out_axi, bbox_x_end_out_axi, bbox_y_end_out_axi,
    input  bbox_valid_out_axi,
    output bbox_ready_axi
  );
endinterface

// File: rtl/detection_bram_reader.sv
// rtl/detection_bram_reader.sv - walks a detection frame in BRAM and presents one bbox at a time
module detection_bram_reader #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int COORD_WIDTH    = 16,
  parameter int MEMORY_WIDTH   = 32,
  parameter int READ_LATENCY   = 1,
  parameter int MAX_DETECTIONS = 31
) (
  input  logic                     clk_axi,
  input  logic                     reset_axi,
  input  logic                     start_axi,
  detection_bram_reader_if.master  bram,
  output logic                     busy_out_axi,
  output logic                     done_out_axi,
  output logic [ADDRESS_WIDTH-1:0] count_out_axi,
  output logic                     clamped_out_axi
);
  typedef enum logic [3:0] {
    IDLE, RD_HEADER, WAIT_HEADER, RD_Y, WAIT_Y, RD_X, WAIT_X, PRESENT, DONE
  } state_t;

  localparam logic [MEMORY_WIDTH-1:0]  MAX_WORD  = MEMORY_WIDTH'(MAX_DETECTIONS);
  localparam logic [ADDRESS_WIDTH-1:0] MAX_COUNT = ADDRESS_WIDTH'(MAX_DETECTIONS);
  localparam logic [ADDRESS_WIDTH-1:0] ONE       = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] Y_OFS     = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] X_OFS     = ADDRESS_WIDTH'(8);
  localparam logic [1:0]               LAST_WAIT = 2'(READ_LATENCY - 1);

  state_t                   state;
  logic [1:0]               wait_cnt;
  logic [ADDRESS_WIDTH-1:0] det_idx;
  logic [ADDRESS_WIDTH-1:0] det_next;
  logic [ADDRESS_WIDTH-1:0] hdr_count;
  logic                     hdr_over;
  logic                     wait_done;
  logic [COORD_WIDTH-1:0]   y_start_q, y_end_q;
  logic [COORD_WIDTH-1:0]   x_start_o, y_start_o, x_end_o, y_end_o;
  logic                     read_en_q, valid_q, busy_q, done_q, clamped_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, count_q;

  // The over-limit test uses the whole header word so huge counts still clamp.
  assign hdr_over  = (bram.read_data_axi > MAX_WORD);
  assign hdr_count = hdr_over ? MAX_COUNT : bram.read_data_axi[ADDRESS_WIDTH-1:0];
  assign wait_done = (wait_cnt == LAST_WAIT);
  assign det_next  = det_idx + ONE;

  always_ff @(posedge clk_axi) begin
    if (reset_axi) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      det_idx   <= '0;
      y_start_q <= '0;
      y_end_q   <= '0;
      x_start_o <= '0;
      y_start_o <= '0;
      x_end_o   <= '0;
      y_end_o   <= '0;
      read_en_q <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      clamped_q <= 1'b0;
    end else begin
      read_en_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        IDLE: if (start_axi) begin
          state     <= RD_HEADER;
          read_en_q <= 1'b1;
          addr_q    <= '0;
          busy_q    <= 1'b1;
          clamped_q <= 1'b0;
        end
        RD_HEADER: begin
          state    <= WAIT_HEADER;
          wait_cnt <= '0;
        end
        WAIT_HEADER: if (wait_done) begin
          det_idx   <= '0;
          count_q   <= hdr_count;
          clamped_q <= hdr_over;
          if (hdr_count == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state     <= RD_Y;
            read_en_q <= 1'b1;
            addr_q    <= Y_OFS;
          end
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        RD_Y: begin
          state    <= WAIT_Y;
          wait_cnt <= '0;
        end
        WAIT_Y: if (wait_done) begin
          y_start_q <= bram.read_data_axi[MEMORY_WIDTH-1:COORD_WIDTH];
          y_end_q   <= bram.read_data_axi[COORD_WIDTH-1:0];
          state     <= RD_X;
          read_en_q <= 1'b1;
          addr_q    <= (det_idx << 3) + X_OFS;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        RD_X: begin
          state    <= WAIT_X;
          wait_cnt <= '0;
        end
        WAIT_X: if (wait_done) begin
          x_start_o <= bram.read_data_axi[MEMORY_WIDTH-1:COORD_WIDTH];
          x_end_o   <= bram.read_data_axi[COORD_WIDTH-1:0];
          y_start_o <= y_start_q;
          y_end_o   <= y_end_q;
          valid_q   <= 1'b1;
          state     <= PRESENT;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        PRESENT: if (bram.bbox_ready_axi) begin
          valid_q <= 1'b0;
          det_idx <= det_next;
          if (det_next == count_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state     <= RD_Y;
            read_en_q <= 1'b1;
            addr_q    <= (det_next << 3) + Y_OFS;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bram.read_en_out_axi      = read_en_q;
  assign bram.read_address_out_axi = addr_q;
  assign bram.bbox_x_start_out_axi = x_start_o;
  assign bram.bbox_y_start_out_axi = y_start_o;
  assign bram.bbox_x_end_out_axi   = x_end_o;
  assign bram.bbox_y_end_out_axi   = y_end_o;
  assign bram.bbox_valid_out_axi   = valid_q;
  assign busy_out_axi              = busy_q;
  assign done_out_axi              = done_q;
  assign count_out_axi             = count_q;
  assign clamped_out_axi           = clamped_q;
endmodule

// File: tb/tb_detection_bram_reader.sv
// tb/tb_detection_bram_reader.sv - two readers (latency 1 and 2) against a frame-level timing model
module tb_detection_bram_reader;
  localparam int AW = 8, CW = 16, MW = 32, MAXD = 31;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk_axi = 1'b0;
  logic reset_axi = 1'b1;
  logic start_axi = 1'b0;
  logic ready = 1'b0;
  always #5 clk_axi = ~clk_axi;

  logic [MW-1:0] mem [256];
  logic [MW-1:0] garb;

  detection_bram_reader_if #(.ADDRESS_WIDTH(AW), .COORD_WIDTH(CW), .MEMORY_WIDTH(MW)) bus0 ();
  detection_bram_reader_if #(.ADDRESS_WIDTH(AW), .COORD_WIDTH(CW), .MEMORY_WIDTH(MW)) bus1 ();

  logic          busy [2];
  logic          done [2];
  logic          clamped [2];
  logic [AW-1:0] count [2];

  detection_bram_reader #(.ADDRESS_WIDTH(AW), .COORD_WIDTH(CW), .MEMORY_WIDTH(MW),
                          .READ_LATENCY(1), .MAX_DETECTIONS(MAXD)) dut0 (
    .clk_axi(clk_axi), .reset_axi(reset_axi), .start_axi(start_axi), .bram(bus0.master),
    .busy_out_axi(busy[0]), .done_out_axi(done[0]), .count_out_axi(count[0]),
    .clamped_out_axi(clamped[0]));

  detection_bram_reader #(.ADDRESS_WIDTH(AW), .COORD_WIDTH(CW), .MEMORY_WIDTH(MW),
                          .READ_LATENCY(2), .MAX_DETECTIONS(MAXD)) dut1 (
    .clk_axi(clk_axi), .reset_axi(reset_axi), .start_axi(start_axi), .bram(bus1.master),
    .busy_out_axi(busy[1]), .done_out_axi(done[1]), .count_out_axi(count[1]),
    .clamped_out_axi(clamped[1]));

  logic          o_ren [2];
  logic [AW-1:0] o_addr [2];
  logic [CW-1:0] o_xs [2], o_ys [2], o_xe [2], o_ye [2];
  logic          o_val [2];
  assign o_ren[0] = bus0.read_en_out_axi;      assign o_ren[1] = bus1.read_en_out_axi;
  assign o_addr[0] = bus0.read_address_out_axi; assign o_addr[1] = bus1.read_address_out_axi;
  assign o_xs[0] = bus0.bbox_x_start_out_axi;  assign o_xs[1] = bus1.bbox_x_start_out_axi;
  assign o_ys[0] = bus0.bbox_y_start_out_axi;  assign o_ys[1] = bus1.bbox_y_start_out_axi;
  assign o_xe[0] = bus0.bbox_x_end_out_axi;    assign o_xe[1] = bus1.bbox_x_end_out_axi;
  assign o_ye[0] = bus0.bbox_y_end_out_axi;    assign o_ye[1] = bus1.bbox_y_end_out_axi;
  assign o_val[0] = bus0.bbox_valid_out_axi;   assign o_val[1] = bus1.bbox_valid_out_axi;
  assign bus0.bbox_ready_axi = ready;
  assign bus1.bbox_ready_axi = ready;

  // BRAM models: data is only meaningful in the exact capture cycle, garbage otherwise
  logic          pv0;
  logic [AW-1:0] pa0;
  logic [1:0]    pv1;
  logic [AW-1:0] pa1 [2];
  always @(posedge clk_axi) begin
    pv0 <= bus0.read_en_out_axi;
    pa0 <= bus0.read_address_out_axi;
    pv1 <= {pv1[0], bus1.read_en_out_axi};
    pa1[0] <= bus1.read_address_out_axi;
    pa1[1] <= pa1[0];
    garb <= $urandom;
  end
  assign bus0.read_data_axi = pv0 ? mem[pa0] : garb;
  assign bus1.read_data_axi = pv1[1] ? mem[pa1[1]] : garb;

  int lat [2] = '{1, 2};
  int m_act [2] = '{0, 0};
  int m_s [2], m_hdr [2], m_y [2], m_x [2], m_vfrom [2], m_done [2], m_k [2], m_cnt [2];
  int m_pend [2] = '{0, 0};
  int m_last_cnt [2] = '{0, 0};
  int m_last_clamp [2] = '{0, 0};
  int post_rst [2] = '{0, 0};

  int st_reads [2] = '{0, 0}, st_boxes [2] = '{0, 0}, st_done [2] = '{0, 0};
  int st_last [2] = '{0, 0}, st_cnt [2] = '{0, 0}, st_clamp [2] = '{0, 0};
  int b_reads [2], b_boxes [2], b_done [2], fbox [2];
  logic [CW-1:0] b0_xs [2], b0_ys [2], b0_xe [2], b0_ye [2];

  int cyc = 0;
  bit chk_on = 1'b0;
  int checks = 0, errors = 0;
  int snap_req = 0, snap_seen = 0, lit_req = 0, lit_seen = 0, lit_id = 0;
  int to_req = 0, to_seen = 0;

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got 0x%0h expected 0x%0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  task automatic sched(input int i, input int t);
    m_y[i] = t;
    m_x[i] = t + lat[i] + 1;
    m_vfrom[i] = t + 2 * lat[i] + 2;
    m_pend[i] = 1;
  endtask

  always @(negedge clk_axi) begin : compare
    bit busy_e, ren_e, val_e, done_e;
    int ea;
    logic [MW-1:0] yw, xw;
    longint hdr;
    if (snap_req != snap_seen) begin
      snap_seen = snap_req;
      for (int i = 0; i < 2; i++) begin
        b_reads[i] = st_reads[i]; b_boxes[i] = st_boxes[i]; b_done[i] = st_done[i]; fbox[i] = 1;
      end
    end
    if (to_req != to_seen) begin
      chk("frame_timeout", 0, to_req - to_seen, 0);
      to_seen = to_req;
    end
    for (int i = 0; i < 2; i++) begin
      busy_e = (m_act[i] != 0) && cyc > m_s[i];
      ren_e  = (m_act[i] != 0) && (cyc == m_hdr[i] || cyc == m_y[i] || cyc == m_x[i]);
      val_e  = (m_act[i] != 0) && (m_pend[i] != 0) && cyc >= m_vfrom[i];
      done_e = (m_act[i] != 0) && cyc == m_done[i];
      ea = (cyc == m_hdr[i]) ? 0 : (cyc == m_y[i]) ? ((4 + 8 * m_k[i]) & 255) : ((8 + 8 * m_k[i]) & 255);
      yw = mem[(4 + 8 * m_k[i]) & 255];
      xw = mem[(8 + 8 * m_k[i]) & 255];
      if (chk_on) begin
        chk("read_en", i, o_ren[i], ren_e);
        if (ren_e) chk("read_addr", i, o_addr[i], ea);
        chk("bbox_valid", i, o_val[i], val_e);
        if (val_e) begin
          chk("x_start", i, o_xs[i], xw[31:16]);
          chk("x_end", i, o_xe[i], xw[15:0]);
          chk("y_start", i, o_ys[i], yw[31:16]);
          chk("y_end", i, o_ye[i], yw[15:0]);
        end
        chk("done", i, done[i], done_e);
        chk("busy", i, busy[i], busy_e);
        if (!busy_e) begin
          chk("count_idle", i, count[i], m_last_cnt[i]);
          chk("clamped_idle", i, clamped[i], m_last_clamp[i]);
        end
        if (post_rst[i] != 0) chk("coords_after_reset", i, {o_xs[i], o_ys[i], o_xe[i], o_ye[i]}, 0);
        if (o_ren[i]) begin st_reads[i]++; st_last[i] = o_addr[i]; end
        if (o_val[i] && ready) begin
          st_boxes[i]++;
          if (fbox[i] != 0) begin
            b0_xs[i] = o_xs[i]; b0_ys[i] = o_ys[i]; b0_xe[i] = o_xe[i]; b0_ye[i] = o_ye[i]; fbox[i] = 0;
          end
        end
        if (done[i]) begin st_done[i]++; st_cnt[i] = count[i]; st_clamp[i] = clamped[i]; end
      end
      post_rst[i] = 0;
      if (val_e && ready) begin
        m_pend[i] = 0;
        m_k[i]++;
        if (m_k[i] == m_cnt[i]) m_done[i] = cyc + 1;
        else sched(i, cyc + 1);
      end
      if (done_e) m_act[i] = 0;
      if (reset_axi) begin
        m_act[i] = 0; m_pend[i] = 0; m_last_cnt[i] = 0; m_last_clamp[i] = 0; post_rst[i] = 1;
      end else if (start_axi && !busy_e) begin
        hdr = mem[0];
        m_cnt[i] = (hdr > MAXD) ? MAXD : int'(hdr);
        m_last_cnt[i] = m_cnt[i];
        m_last_clamp[i] = (hdr > MAXD) ? 1 : 0;
        m_act[i] = 1; m_s[i] = cyc; m_hdr[i] = cyc + 1; m_k[i] = 0; m_pend[i] = 0;
        m_y[i] = NEVER; m_x[i] = NEVER;
        if (m_cnt[i] == 0) m_done[i] = cyc + lat[i] + 2;
        else begin m_done[i] = NEVER; sched(i, cyc + lat[i] + 2); end
      end
    end
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      for (int i = 0; i < 2; i++) begin
        case (lit_id)
          1: begin
            chk("hdr0_reads", i, st_reads[i] - b_reads[i], 1);
            chk("hdr0_addr", i, st_last[i], 0);
            chk("hdr0_boxes", i, st_boxes[i] - b_boxes[i], 0);
            chk("hdr0_done", i, st_done[i] - b_done[i], 1);
            chk("hdr0_count", i, st_cnt[i], 0);
          end
          2: begin
            chk("two_reads", i, st_reads[i] - b_reads[i], 5);
            chk("two_last_addr", i, st_last[i], 8'h10);
            chk("two_boxes", i, st_boxes[i] - b_boxes[i], 2);
            chk("two_count", i, st_cnt[i], 2);
            chk("box0_x_start", i, b0_xs[i], 16'h20);
            chk("box0_y_start", i, b0_ys[i], 16'h10);
            chk("box0_x_end", i, b0_xe[i], 16'h60);
            chk("box0_y_end", i, b0_ye[i], 16'h50);
          end
          3: begin
            chk("stall_reads", i, st_reads[i] - b_reads[i], 3);
            chk("stall_boxes", i, st_boxes[i] - b_boxes[i], 1);
            chk("stall_done", i, st_done[i] - b_done[i], 1);
          end
          4: begin
            chk("clamp_count", i, st_cnt[i], 31);
            chk("clamp_flag", i, st_clamp[i], 1);
            chk("clamp_boxes", i, st_boxes[i] - b_boxes[i], 31);
            chk("clamp_reads", i, st_reads[i] - b_reads[i], 63);
            chk("clamp_last_addr", i, st_last[i], 8'hF8);
          end
          5: begin
            chk("abort_done", i, st_done[i] - b_done[i], 0);
            chk("abort_reads", i, st_reads[i] - b_reads[i], (i == 0) ? 4 : 3);
            chk("abort_last_addr", i, st_last[i], (i == 0) ? 8'h0C : 8'h08);
          end
          6: begin
            chk("restart_reads", i, st_reads[i] - b_reads[i], 1);
            chk("restart_addr", i, st_last[i], 0);
            chk("restart_done", i, st_done[i] - b_done[i], 1);
          end
          default: ;
        endcase
      end
    end
    if (reset_axi) chk_on = 1'b1;
    cyc++;
  end

  task automatic tick();
    @(posedge clk_axi);
    #1;
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low for 20 cycles then high
  task automatic run_frame(input logic [MW-1:0] hdr, input int rmode, input bit extra, input int rst_at);
    int t;
    mem[0] = hdr;
    start_axi = 1'b1;
    ready = (rmode != 2);
    tick();
    start_axi = 1'b0;
    t = 0;
    while ((m_act[0] != 0 || m_act[1] != 0) && t < 3000) begin
      case (rmode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 3) != 0);
        default: ready = (t >= 20);
      endcase
      start_axi = extra && m_act[0] != 0 && m_act[1] != 0 && $urandom_range(0, 5) == 0;
      reset_axi = (t == rst_at);
      tick();
      t++;
    end
    start_axi = 1'b0;
    reset_axi = 1'b0;
    if (t >= 3000) to_req++;
    tick();
    tick();
  endtask

  task automatic fill_mem();
    for (int j = 0; j < 256; j++) mem[j] = $urandom;
  endtask

  task automatic lit(input int id);
    lit_id = id;
    lit_req++;
    tick();
  endtask

  initial begin
    logic [MW-1:0] h;
    fill_mem();
    reset_axi = 1'b1;
    repeat (3) tick();
    reset_axi = 1'b0;
    tick();

    snap_req++; run_frame(0, 0, 0, -1); lit(1);

    mem[4] = 32'h0010_0050; mem[8] = 32'h0020_0060;
    mem[12] = 32'h0011_0051; mem[16] = 32'h0021_0061;
    snap_req++; run_frame(2, 0, 0, -1); lit(2);

    snap_req++; run_frame(1, 2, 1, -1); lit(3);

    fill_mem();
    snap_req++; run_frame(40, 1, 1, -1); lit(4);

    snap_req++; run_frame(3, 0, 0, 8); lit(5);

    snap_req++; run_frame(0, 0, 0, -1); lit(6);

    for (int f = 0; f < 30; f++) begin
      fill_mem();
      case ($urandom_range(0, 5))
        0: h = 0;
        1: h = MAXD;
        2: h = MAXD + 1;
        3: h = $urandom | 32'h0001_0000;
        default: h = $urandom_range(1, 12);
      endcase
      run_frame(h, 1, 1, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 60)) : -1);
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
